// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM driver: direction codes, channel
// state encoding, bridge pin payload and a small code-decoding helper.
package motor_pkg;

  // Per-pair direction codes as delivered by the steering logic
  localparam logic [1:0] CODE_COAST = 2'b00;
  localparam logic [1:0] CODE_A     = 2'b10;
  localparam logic [1:0] CODE_B     = 2'b01;
  localparam logic [1:0] CODE_ILL   = 2'b11;

  // Channel state
  typedef enum logic [1:0] {
    COAST   = 2'b00,
    DEAD    = 2'b01,
    DRIVE_A = 2'b10,
    DRIVE_B = 2'b11
  } chan_state_e;

  // One H-bridge input pair, {IN1, IN2}
  typedef struct packed {
    logic in1;
    logic in2;
  } bridge_pair_t;

  // Illegal code: both bridge legs requested at once
  function automatic logic is_illegal(input logic [1:0] code);
    return code == CODE_ILL;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: direction FSM with break-before-make dead time and a
// soft-start duty ramp, producing a registered PWM-gated bridge pair.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   enable_i        low forces COAST and clears duty/dead counter
//   code_i          synchronised 2-bit direction code
//   pwm_cnt_i       PWM counter value that will be current after this edge
//   wrap_i          counter wraps max->0 on this edge
//   ramp_tick_i     ramp step due on this edge (only with wrap_i)
//   duty_max_i      duty ceiling
//   bridge_o        registered {IN1, IN2}
//   dead_active_o   registered, high while in dead time
//   illegal_c       combinational, code_i is 2'b11
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned RAMP_START  = 64,
  parameter int unsigned RAMP_STEP   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [1:0]          code_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                wrap_i,
  input  logic                ramp_tick_i,
  input  logic [PWM_BITS-1:0] duty_max_i,
  output bridge_pair_t        bridge_o,
  output logic                dead_active_o,
  output logic                illegal_c
);

  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PWM_BITS:0] START_EXT = (PWM_BITS+1)'(RAMP_START);
  localparam logic [PWM_BITS:0] STEP_EXT  = (PWM_BITS+1)'(RAMP_STEP);

  chan_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  bridge_pair_t        bridge_q, bridge_d;
  logic                dead_active_q, dead_active_d;

  logic                want_a_c, want_b_c;
  logic [PWM_BITS:0]   dmax_ext_c;
  logic [PWM_BITS:0]   sum_c;
  logic [PWM_BITS-1:0] start_duty_c;
  logic [PWM_BITS-1:0] ramp_duty_c;
  logic                pwm_on_c;

  assign want_a_c  = (code_i == CODE_A);
  assign want_b_c  = (code_i == CODE_B);
  assign illegal_c = is_illegal(code_i);

  // Duty arithmetic one bit wider so the ramp step can never wrap
  assign dmax_ext_c   = {1'b0, duty_max_i};
  assign sum_c        = {1'b0, duty_q} + STEP_EXT;
  assign start_duty_c = (START_EXT < dmax_ext_c) ? START_EXT[PWM_BITS-1:0] : duty_max_i;

  // Wrap-time duty: step on a ramp tick, otherwise only clamp to a lowered ceiling
  always_comb begin
    ramp_duty_c = duty_q;
    if (ramp_tick_i) begin
      ramp_duty_c = (sum_c > dmax_ext_c) ? duty_max_i : sum_c[PWM_BITS-1:0];
    end else if (duty_q > duty_max_i) begin
      ramp_duty_c = duty_max_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    if (!enable_i) begin
      state_d = COAST;
      duty_d  = '0;
      dead_d  = '0;
    end else begin
      case (state_q)
        COAST: begin
          if (want_a_c) begin
            state_d = DRIVE_A;
            duty_d  = start_duty_c;
          end else if (want_b_c) begin
            state_d = DRIVE_B;
            duty_d  = start_duty_c;
          end
        end
        DRIVE_A: begin
          if (want_a_c) begin
            if (wrap_i) duty_d = ramp_duty_c;
          end else if (want_b_c) begin
            state_d = DEAD;
            dead_d  = DEAD_W'(DEAD_CYCLES - 1);
            duty_d  = '0;
          end else begin
            state_d = COAST;
            duty_d  = '0;
          end
        end
        DRIVE_B: begin
          if (want_b_c) begin
            if (wrap_i) duty_d = ramp_duty_c;
          end else if (want_a_c) begin
            state_d = DEAD;
            dead_d  = DEAD_W'(DEAD_CYCLES - 1);
            duty_d  = '0;
          end else begin
            state_d = COAST;
            duty_d  = '0;
          end
        end
        DEAD: begin
          // Exit direction follows the code current at expiry, never earlier
          if (dead_q == '0) begin
            if (want_a_c) begin
              state_d = DRIVE_A;
              duty_d  = start_duty_c;
            end else if (want_b_c) begin
              state_d = DRIVE_B;
              duty_d  = start_duty_c;
            end else begin
              state_d = COAST;
              duty_d  = '0;
            end
          end else begin
            dead_d = dead_q - DEAD_W'(1);
          end
        end
        default: begin
          state_d = COAST;
          duty_d  = '0;
          dead_d  = '0;
        end
      endcase
    end
  end

  // Pins registered from next state so they move on the same edge as the FSM
  assign pwm_on_c = (pwm_cnt_i < duty_d);

  always_comb begin
    bridge_d      = '0;
    dead_active_d = 1'b0;
    case (state_d)
      DRIVE_A: bridge_d.in1   = pwm_on_c;
      DRIVE_B: bridge_d.in2   = pwm_on_c;
      DEAD:    dead_active_d  = 1'b1;
      default: bridge_d       = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COAST;
      duty_q        <= '0;
      dead_q        <= '0;
      bridge_q      <= '0;
      dead_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      dead_q        <= dead_d;
      bridge_q      <= bridge_d;
      dead_active_q <= dead_active_d;
    end
  end

  assign bridge_o      = bridge_q;
  assign dead_active_o = dead_active_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: synchronises the steering direction code, runs the
// shared PWM counter and ramp divider, and drives two motor channels.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   enable        high permits drive, low forces coast
//   motor_cmd     [3:2] left, [1:0] right direction code (asynchronous)
//   duty_max      ramped duty ceiling (synchronous)
//   hbridge       registered bridge inputs, {L_IN1, L_IN2, R_IN1, R_IN2}
//   dead_active   registered {left, right} dead-time flags
//   cmd_err       registered, high each cycle a synchronised pair is 2'b11
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned RAMP_START  = 64,
  parameter int unsigned RAMP_STEP   = 32,
  parameter int unsigned RAMP_DIV    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [3:0]          motor_cmd,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic [3:0]          hbridge,
  output logic [1:0]          dead_active,
  output logic                cmd_err
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [3:0]          sync1_q, sync2_q;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cmd_err_q, cmd_err_d;
  logic                wrap_c, ramp_tick_c;
  logic                left_ill_c, right_ill_c;
  bridge_pair_t        left_bridge, right_bridge;
  logic                left_dead, right_dead;

  // Two-flop synchroniser for the asynchronous command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= motor_cmd;
      sync2_q <= sync1_q;
    end
  end

  // Free-running PWM counter and wrap-counting ramp divider
  assign wrap_c      = &cnt_q;
  assign ramp_tick_c = wrap_c && (div_q == DIV_W'(RAMP_DIV - 1));
  assign cnt_d       = cnt_q + PWM_BITS'(1);

  always_comb begin
    div_d = div_q;
    if (wrap_c) div_d = ramp_tick_c ? '0 : div_q + DIV_W'(1);
  end

  assign cmd_err_d = left_ill_c | right_ill_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_CYCLES (DEAD_CYCLES),
    .RAMP_START  (RAMP_START),
    .RAMP_STEP   (RAMP_STEP)
  ) u_left (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .code_i        (sync2_q[3:2]),
    .pwm_cnt_i     (cnt_d),
    .wrap_i        (wrap_c),
    .ramp_tick_i   (ramp_tick_c),
    .duty_max_i    (duty_max),
    .bridge_o      (left_bridge),
    .dead_active_o (left_dead),
    .illegal_c     (left_ill_c)
  );

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_CYCLES (DEAD_CYCLES),
    .RAMP_START  (RAMP_START),
    .RAMP_STEP   (RAMP_STEP)
  ) u_right (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .code_i        (sync2_q[1:0]),
    .pwm_cnt_i     (cnt_d),
    .wrap_i        (wrap_c),
    .ramp_tick_i   (ramp_tick_c),
    .duty_max_i    (duty_max),
    .bridge_o      (right_bridge),
    .dead_active_o (right_dead),
    .illegal_c     (right_ill_c)
  );

  assign hbridge     = {left_bridge, right_bridge};
  assign dead_active = {left_dead, right_dead};
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios plus random command,
// ceiling, enable and reset traffic, checked cycle by cycle against an
// arithmetic reference model and by per-period pulse-width counts.
module tb_motor_pwm_driver;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] motor_cmd;
  logic [7:0] duty_max;
  logic [3:0] hbridge;
  logic [1:0] dead_active;
  logic       cmd_err;

  int n_tests;
  int n_fail;
  string phase;

  // Reference model: mode 0 coast, 1 dir A, 2 dir B, 3 dead
  logic [3:0] m_s1, m_s2;
  int         m_cnt;
  int         m_mode [2];
  int         m_duty [2];
  int         m_dead [2];
  logic [3:0] m_hb;
  logic [1:0] m_da;
  logic       m_err;

  motor_pwm_driver #(
    .PWM_BITS    (8),
    .DEAD_CYCLES (16),
    .RAMP_START  (64),
    .RAMP_STEP   (32),
    .RAMP_DIV    (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .motor_cmd   (motor_cmd),
    .duty_max    (duty_max),
    .hbridge     (hbridge),
    .dead_active (dead_active),
    .cmd_err     (cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_cnt = 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_mode[ch] = 0; m_duty[ch] = 0; m_dead[ch] = 0;
    end
    m_hb = '0; m_da = '0; m_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    int cnt_n, code, dir, start, dmax;
    bit wrap, on;
    logic [1:0] pair;
    logic [3:0] hb;
    logic [1:0] da;
    wrap  = (m_cnt == 255);
    cnt_n = (m_cnt + 1) % 256;
    dmax  = int'(duty_max);
    start = (dmax < 64) ? dmax : 64;
    hb = '0; da = '0;
    for (int ch = 0; ch < 2; ch++) begin
      code = (ch == 0) ? int'(m_s2[3:2]) : int'(m_s2[1:0]);
      dir  = (code == 2) ? 1 : ((code == 1) ? 2 : 0);
      if (!enable) begin
        m_mode[ch] = 0; m_duty[ch] = 0; m_dead[ch] = 0;
      end else if (m_mode[ch] == 0) begin
        if (dir != 0) begin m_mode[ch] = dir; m_duty[ch] = start; end
      end else if (m_mode[ch] == 3) begin
        if (m_dead[ch] == 0) begin
          m_mode[ch] = dir;
          m_duty[ch] = (dir != 0) ? start : 0;
        end else begin
          m_dead[ch] = m_dead[ch] - 1;
        end
      end else if (dir == m_mode[ch]) begin
        if (wrap) m_duty[ch] = (m_duty[ch] + 32 < dmax) ? m_duty[ch] + 32 : dmax;
      end else if (dir == 0) begin
        m_mode[ch] = 0; m_duty[ch] = 0;
      end else begin
        m_mode[ch] = 3; m_dead[ch] = 15;
      end
      on   = (cnt_n < m_duty[ch]);
      pair = (m_mode[ch] == 1) ? {on, 1'b0} : ((m_mode[ch] == 2) ? {1'b0, on} : 2'b00);
      if (ch == 0) hb[3:2] = pair; else hb[1:0] = pair;
      da[1-ch] = (m_mode[ch] == 3);
    end
    m_err = (m_s2[3:2] == 2'b11) || (m_s2[1:0] == 2'b11);
    m_s2  = m_s1;
    m_s1  = motor_cmd;
    m_cnt = cnt_n;
    m_hb  = hb;
    m_da  = da;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    n_tests++;
    assert ({hbridge, dead_active, cmd_err} === {m_hb, m_da, m_err}) else begin
      n_fail++;
      $error("FAIL cycle[%s] cnt=%0d observed hb=%b da=%b err=%b expected hb=%b da=%b err=%b",
             phase, m_cnt, hbridge, dead_active, cmd_err, m_hb, m_da, m_err);
    end
  endtask

  task automatic align_to(input int c);
    int guard;
    guard = 0;
    while (m_cnt != c && guard < 300) begin
      tick();
      guard++;
    end
    n_tests++;
    if (m_cnt != c) begin
      n_fail++;
      $error("FAIL align: counter %0d never reached %0d", m_cnt, c);
    end
  endtask

  // High-time of each bridge pin over the next 256 clocks
  task automatic run_period(output int l1, output int l2, output int r1, output int r2);
    l1 = 0; l2 = 0; r1 = 0; r2 = 0;
    repeat (256) begin
      tick();
      l1 += int'(hbridge[3]); l2 += int'(hbridge[2]);
      r1 += int'(hbridge[1]); r2 += int'(hbridge[0]);
    end
  endtask

  initial begin
    int l1, l2, r1, r2, s_a, s_b, s_c;
    int exp_ss [7];
    exp_ss = '{64, 96, 128, 160, 192, 200, 200};
    n_tests = 0; n_fail = 0;
    phase = "reset";
    rst_n = 1'b0; enable = 1'b1; motor_cmd = 4'b0000; duty_max = 8'd200;
    model_reset();
    repeat (3) tick();
    check("reset_outputs", int'({hbridge, dead_active, cmd_err}), 0);
    rst_n = 1'b1;
    repeat (20) tick();

    // Soft start aligned so the channels enter DRIVE on a counter wrap
    phase = "soft_start";
    align_to(253);
    motor_cmd = 4'b1010;
    tick(); tick();
    for (int p = 0; p < 7; p++) begin
      run_period(l1, l2, r1, r2);
      check($sformatf("ss_left_in1_p%0d", p), l1, exp_ss[p]);
      check($sformatf("ss_right_in1_p%0d", p), r1, exp_ss[p]);
      check($sformatf("ss_in2_p%0d", p), l2 + r2, 0);
    end

    // Left reversal with right untouched
    phase = "reversal";
    motor_cmd = 4'b0110;
    s_a = 0; s_b = 0;
    repeat (40) begin
      tick();
      s_a += int'(dead_active[1]); s_b += int'(dead_active[0]);
    end
    check("rev_left_dead_clocks", s_a, 16);
    check("rev_right_dead_clocks", s_b, 0);
    repeat (600) tick();

    // Asynchronous reset during dead time
    phase = "reset_mid";
    motor_cmd = 4'b1010;
    repeat (6) tick();
    check("dead_before_reset", int'(dead_active[1]), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_hb", int'(hbridge), 0);
    check("async_reset_da", int'(dead_active), 0);
    repeat (3) tick();
    motor_cmd = 4'b0000;
    rst_n = 1'b1;
    s_a = 0;
    repeat (50) begin
      tick();
      s_a += int'(hbridge != 4'b0000);
    end
    check("post_reset_idle", s_a, 0);

    // Flip back to the original direction inside the dead window
    phase = "flip_back";
    motor_cmd = 4'b1010;
    repeat (600) tick();
    motor_cmd = 4'b0110;
    s_a = 0;
    repeat (5) begin tick(); s_a += int'(dead_active[1]); end
    motor_cmd = 4'b1010;
    repeat (40) begin tick(); s_a += int'(dead_active[1]); end
    check("flip_dead_clocks", s_a, 16);
    repeat (300) tick();

    // Illegal left code while right keeps driving
    phase = "illegal";
    motor_cmd = 4'b1110;
    s_a = 0; s_b = 0; s_c = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i >= 3) s_a += int'(hbridge[3]) + int'(hbridge[2]);
      s_b += int'(hbridge[1]);
      s_c += int'(cmd_err);
    end
    check("ill_left_pins", s_a, 0);
    check("ill_right_drives", int'(s_b > 0), 1);
    check("ill_err_clocks", s_c, 298);

    // Enable drop and re-enable
    phase = "enable";
    enable = 1'b0;
    tick();
    check("en_off_hb", int'(hbridge), 0);
    motor_cmd = 4'b1010;
    repeat (20) tick();
    align_to(255);
    enable = 1'b1;
    run_period(l1, l2, r1, r2);
    check("reen_left_p0", l1, 64);
    check("reen_right_p0", r1, 64);
    run_period(l1, l2, r1, r2);
    check("reen_left_p1", l1, 96);

    // Duty ceiling changes
    phase = "ceiling";
    repeat (4) run_period(l1, l2, r1, r2);
    check("ceil_start", l1, 200);
    align_to(100);
    duty_max = 8'd100;
    align_to(255);
    run_period(l1, l2, r1, r2);
    check("ceil_100_left", l1, 100);
    check("ceil_100_right", r1, 100);
    duty_max = 8'd0;
    run_period(l1, l2, r1, r2);
    check("ceil_0_pins", l1 + l2 + r1 + r2, 0);
    duty_max = 8'd200;
    run_period(l1, l2, r1, r2);
    check("ceil_resume_left", l1, 32);

    // Random traffic against the model
    phase = "random";
    for (int it = 0; it < 40; it++) begin
      motor_cmd = 4'($urandom_range(0, 15));
      duty_max  = 8'($urandom_range(0, 255));
      enable    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_reset", int'({hbridge, dead_active}), 0);
        repeat (2) tick();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 400)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
